// File: rtl/rv_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU operation and immediate-format
// encodings, the decode/execute register layout and small decode helpers.
package rv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    alu_op_e     alu_op;
    logic        reg_we;
    logic        mem_re;
    logic        mem_we;
    logic        branch;
    logic        jump;
    logic        alu_src_imm;
    logic        alu_src_pc;
    logic        illegal;
  } de_reg_t;

  function automatic logic [31:0] gen_imm(input logic [31:0] instr, input imm_fmt_e fmt);
    logic [31:0] imm;
    case (fmt)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'h000};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = 32'h0000_0000;
    endcase
    return imm;
  endfunction

  // instr[30] selects SUB only for register-register ops; SRA for both forms.
  function automatic alu_op_e alu_from_funct3(input logic [2:0] f3, input logic alt,
                                              input logic is_reg);
    alu_op_e op;
    case (f3)
      3'b000:  op = (alt && is_reg) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/register_file.sv
// Architectural register file: two combinational read ports with same-cycle
// writeback bypass, one synchronous write port, x0 hardwired to zero.
module register_file
  import rv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            wr_en,
  input  logic [4:0]      wr_addr,
  input  logic [XLEN-1:0] wr_data
);

  logic [XLEN-1:0] regs_r [NREGS];

  // Storage update; entry 0 is never written so it stays at its reset value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= '0;
      end
    end else if (wr_en && (wr_addr != 5'd0)) begin
      regs_r[wr_addr] <= wr_data;
    end else begin
      regs_r[0] <= '0;
    end
  end

  // Read port 1 with writeback bypass.
  always_comb begin
    rs1_data = '0;
    if (rs1_addr == 5'd0) begin
      rs1_data = '0;
    end else if (wr_en && (wr_addr == rs1_addr)) begin
      rs1_data = wr_data;
    end else begin
      rs1_data = regs_r[rs1_addr];
    end
  end

  // Read port 2 with writeback bypass.
  always_comb begin
    rs2_data = '0;
    if (rs2_addr == 5'd0) begin
      rs2_data = '0;
    end else if (wr_en && (wr_addr == rs2_addr)) begin
      rs2_data = wr_data;
    end else begin
      rs2_data = regs_r[rs2_addr];
    end
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: instruction decode, immediate generation, register read
// and the decode/execute pipeline register with flush and stall control.
module decode_stage
  import rv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     InstrD,
  input  logic [XLEN-1:0] PC_DE,
  input  logic            FLUSH,
  input  logic            STALL,
  input  logic            WB_EN,
  input  logic [4:0]      WB_RD,
  input  logic [XLEN-1:0] WB_DATA,
  output logic            VALID_EX,
  output logic [XLEN-1:0] PC_EX,
  output logic [XLEN-1:0] IMM_EX,
  output logic [XLEN-1:0] RS1_VAL_EX,
  output logic [XLEN-1:0] RS2_VAL_EX,
  output logic [4:0]      RD_EX,
  output logic [2:0]      FUNCT3_EX,
  output logic [3:0]      ALU_OP_EX,
  output logic            REG_WE_EX,
  output logic            MEM_RE_EX,
  output logic            MEM_WE_EX,
  output logic            BRANCH_EX,
  output logic            JUMP_EX,
  output logic            ALU_SRC_IMM_EX,
  output logic            ALU_SRC_PC_EX,
  output logic            ILLEGAL_EX
);

  logic [6:0]  opcode_s;
  logic [2:0]  funct3_s;
  logic [4:0]  rs1_s;
  logic [4:0]  rs2_s;
  logic [31:0] rs1_val_s;
  logic [31:0] rs2_val_s;
  imm_fmt_e    imm_fmt_s;
  de_reg_t     dec_s;
  de_reg_t     de_r;

  assign opcode_s = InstrD[6:0];
  assign funct3_s = InstrD[14:12];
  assign rs1_s    = InstrD[19:15];
  assign rs2_s    = InstrD[24:20];

  register_file #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_register_file (
    .clk      (clk),
    .rst      (rst),
    .rs1_addr (rs1_s),
    .rs2_addr (rs2_s),
    .rs1_data (rs1_val_s),
    .rs2_data (rs2_val_s),
    .wr_en    (WB_EN),
    .wr_addr  (WB_RD),
    .wr_data  (WB_DATA)
  );

  // Instruction decode and immediate generation; an all-zero word is a bubble.
  always_comb begin
    dec_s     = '0;
    imm_fmt_s = IMM_NONE;
    if (InstrD == 32'h0000_0000) begin
      dec_s = '0;
    end else begin
      dec_s.valid   = 1'b1;
      dec_s.pc      = PC_DE;
      dec_s.rs1_val = rs1_val_s;
      dec_s.rs2_val = rs2_val_s;
      dec_s.rd      = InstrD[11:7];
      dec_s.funct3  = funct3_s;
      case (opcode_s)
        OPC_LUI: begin
          imm_fmt_s         = IMM_U;
          dec_s.alu_op      = ALU_PASSB;
          dec_s.reg_we      = 1'b1;
          dec_s.alu_src_imm = 1'b1;
        end
        OPC_AUIPC: begin
          imm_fmt_s         = IMM_U;
          dec_s.alu_op      = ALU_ADD;
          dec_s.reg_we      = 1'b1;
          dec_s.alu_src_pc  = 1'b1;
          dec_s.alu_src_imm = 1'b1;
        end
        OPC_JAL: begin
          imm_fmt_s         = IMM_J;
          dec_s.alu_op      = ALU_ADD;
          dec_s.reg_we      = 1'b1;
          dec_s.jump        = 1'b1;
          dec_s.alu_src_pc  = 1'b1;
          dec_s.alu_src_imm = 1'b1;
        end
        OPC_JALR: begin
          imm_fmt_s         = IMM_I;
          dec_s.alu_op      = ALU_ADD;
          dec_s.reg_we      = 1'b1;
          dec_s.jump        = 1'b1;
          dec_s.alu_src_imm = 1'b1;
        end
        OPC_BRANCH: begin
          imm_fmt_s    = IMM_B;
          dec_s.alu_op = ALU_SUB;
          dec_s.branch = 1'b1;
        end
        OPC_LOAD: begin
          imm_fmt_s         = IMM_I;
          dec_s.alu_op      = ALU_ADD;
          dec_s.mem_re      = 1'b1;
          dec_s.reg_we      = 1'b1;
          dec_s.alu_src_imm = 1'b1;
        end
        OPC_STORE: begin
          imm_fmt_s         = IMM_S;
          dec_s.alu_op      = ALU_ADD;
          dec_s.mem_we      = 1'b1;
          dec_s.alu_src_imm = 1'b1;
        end
        OPC_OP_IMM: begin
          imm_fmt_s         = IMM_I;
          dec_s.alu_op      = alu_from_funct3(funct3_s, InstrD[30], 1'b0);
          dec_s.reg_we      = 1'b1;
          dec_s.alu_src_imm = 1'b1;
        end
        OPC_OP: begin
          imm_fmt_s    = IMM_NONE;
          dec_s.alu_op = alu_from_funct3(funct3_s, InstrD[30], 1'b1);
          dec_s.reg_we = 1'b1;
        end
        default: begin
          imm_fmt_s     = IMM_NONE;
          dec_s.alu_op  = ALU_ADD;
          dec_s.illegal = 1'b1;
        end
      endcase
      dec_s.imm = gen_imm(InstrD, imm_fmt_s);
    end
  end

  // Decode/execute register: flush outranks stall, which outranks a fresh load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      de_r <= '0;
    end else if (FLUSH) begin
      de_r <= '0;
    end else if (STALL) begin
      de_r <= de_r;
    end else begin
      de_r <= dec_s;
    end
  end

  assign VALID_EX       = de_r.valid;
  assign PC_EX          = de_r.pc;
  assign IMM_EX         = de_r.imm;
  assign RS1_VAL_EX     = de_r.rs1_val;
  assign RS2_VAL_EX     = de_r.rs2_val;
  assign RD_EX          = de_r.rd;
  assign FUNCT3_EX      = de_r.funct3;
  assign ALU_OP_EX      = de_r.alu_op;
  assign REG_WE_EX      = de_r.reg_we;
  assign MEM_RE_EX      = de_r.mem_re;
  assign MEM_WE_EX      = de_r.mem_we;
  assign BRANCH_EX      = de_r.branch;
  assign JUMP_EX        = de_r.jump;
  assign ALU_SRC_IMM_EX = de_r.alu_src_imm;
  assign ALU_SRC_PC_EX  = de_r.alu_src_pc;
  assign ILLEGAL_EX     = de_r.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed vector table, hand-written
// stall/reset sequences and randomized traffic against a behavioural model.
module tb_decode_stage;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [3:0]  alu;
    logic        reg_we;
    logic        mem_re;
    logic        mem_we;
    logic        branch;
    logic        jump;
    logic        src_imm;
    logic        src_pc;
    logic        illegal;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        wen;
    logic [4:0]  wrd;
    logic [31:0] wdata;
    logic        flush;
    logic        stall;
    exp_t        exp;
  } vec_t;

  localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_SLL = 4'd2, A_SLT = 4'd3,
                         A_SLTU = 4'd4, A_XOR = 4'd5, A_SRL = 4'd6, A_SRA = 4'd7,
                         A_OR = 4'd8, A_AND = 4'd9, A_PASSB = 4'd10;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] InstrD, PC_DE, WB_DATA;
  logic        FLUSH, STALL, WB_EN;
  logic [4:0]  WB_RD;
  logic        VALID_EX, REG_WE_EX, MEM_RE_EX, MEM_WE_EX, BRANCH_EX, JUMP_EX;
  logic        ALU_SRC_IMM_EX, ALU_SRC_PC_EX, ILLEGAL_EX;
  logic [31:0] PC_EX, IMM_EX, RS1_VAL_EX, RS2_VAL_EX;
  logic [4:0]  RD_EX;
  logic [2:0]  FUNCT3_EX;
  logic [3:0]  ALU_OP_EX;

  int checks = 0;
  int errors = 0;

  logic [31:0] mregs [32];
  exp_t        mexp;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .NREGS(32)) dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PC_DE(PC_DE), .FLUSH(FLUSH), .STALL(STALL),
    .WB_EN(WB_EN), .WB_RD(WB_RD), .WB_DATA(WB_DATA), .VALID_EX(VALID_EX), .PC_EX(PC_EX),
    .IMM_EX(IMM_EX), .RS1_VAL_EX(RS1_VAL_EX), .RS2_VAL_EX(RS2_VAL_EX), .RD_EX(RD_EX),
    .FUNCT3_EX(FUNCT3_EX), .ALU_OP_EX(ALU_OP_EX), .REG_WE_EX(REG_WE_EX),
    .MEM_RE_EX(MEM_RE_EX), .MEM_WE_EX(MEM_WE_EX), .BRANCH_EX(BRANCH_EX), .JUMP_EX(JUMP_EX),
    .ALU_SRC_IMM_EX(ALU_SRC_IMM_EX), .ALU_SRC_PC_EX(ALU_SRC_PC_EX), .ILLEGAL_EX(ILLEGAL_EX)
  );

  function automatic exp_t dut_out();
    exp_t o;
    o = {VALID_EX, PC_EX, IMM_EX, RS1_VAL_EX, RS2_VAL_EX, RD_EX, FUNCT3_EX, ALU_OP_EX,
         REG_WE_EX, MEM_RE_EX, MEM_WE_EX, BRANCH_EX, JUMP_EX, ALU_SRC_IMM_EX,
         ALU_SRC_PC_EX, ILLEGAL_EX};
    return o;
  endfunction

  // ctl = {reg_we, mem_re, mem_we, branch, jump, src_imm, src_pc, illegal}
  function automatic exp_t mkexp(input logic v, input logic [31:0] pc, input logic [31:0] imm,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] rd, input logic [2:0] f3,
                                 input logic [3:0] alu, input logic [7:0] ctl);
    exp_t e;
    e = {v, pc, imm, a, b, rd, f3, alu, ctl};
    return e;
  endfunction

  // Reference decoder built from the instruction-set rules.
  function automatic exp_t ref_decode(input logic [31:0] i, input logic [31:0] pc,
                                      input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [3:0]  by_f3 [8];
    logic [20:0] j;
    logic [12:0] br;
    e = '0;
    by_f3 = '{A_ADD, A_SLL, A_SLT, A_SLTU, A_XOR, A_SRL, A_OR, A_AND};
    if (i == 32'h0) return e;
    e.valid = 1'b1; e.pc = pc; e.rs1 = a; e.rs2 = b; e.rd = i[11:7]; e.f3 = i[14:12];
    j  = {i[31], i[19:12], i[20], i[30:21], 1'b0};
    br = {i[31], i[7], i[30:25], i[11:8], 1'b0};
    case (i[6:0])
      7'h37: begin e.imm = i & 32'hFFFF_F000; e.alu = A_PASSB; e.reg_we = 1'b1; e.src_imm = 1'b1; end
      7'h17: begin e.imm = i & 32'hFFFF_F000; e.reg_we = 1'b1; e.src_pc = 1'b1; e.src_imm = 1'b1; end
      7'h6F: begin e.imm = {{11{j[20]}}, j}; e.reg_we = 1'b1; e.jump = 1'b1;
                   e.src_pc = 1'b1; e.src_imm = 1'b1; end
      7'h67: begin e.imm = {{20{i[31]}}, i[31:20]}; e.reg_we = 1'b1; e.jump = 1'b1; e.src_imm = 1'b1; end
      7'h63: begin e.imm = {{19{br[12]}}, br}; e.alu = A_SUB; e.branch = 1'b1; end
      7'h03: begin e.imm = {{20{i[31]}}, i[31:20]}; e.mem_re = 1'b1; e.reg_we = 1'b1; e.src_imm = 1'b1; end
      7'h23: begin e.imm = {{20{i[31]}}, i[31:25], i[11:7]}; e.mem_we = 1'b1; e.src_imm = 1'b1; end
      7'h13: begin
        e.imm = {{20{i[31]}}, i[31:20]}; e.reg_we = 1'b1; e.src_imm = 1'b1;
        e.alu = (i[14:12] == 3'd5 && i[30]) ? A_SRA : by_f3[i[14:12]];
      end
      7'h33: begin
        e.reg_we = 1'b1;
        if (i[14:12] == 3'd0 && i[30]) e.alu = A_SUB;
        else if (i[14:12] == 3'd5 && i[30]) e.alu = A_SRA;
        else e.alu = by_f3[i[14:12]];
      end
      default: e.illegal = 1'b1;
    endcase
    return e;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) mregs[r] = 32'h0;
    mexp = '0;
  endtask

  task automatic check(input string name, input exp_t got, input exp_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Drive one cycle; the model sees this cycle's writeback before reading.
  task automatic apply(input logic [31:0] instr, input logic [31:0] pc, input logic wen,
                       input logic [4:0] wrd, input logic [31:0] wdata,
                       input logic fl, input logic st);
    exp_t d;
    InstrD = instr; PC_DE = pc; WB_EN = wen; WB_RD = wrd; WB_DATA = wdata;
    FLUSH = fl; STALL = st;
    if (wen && wrd != 5'd0) mregs[wrd] = wdata;
    d = ref_decode(instr, pc, (instr[19:15] == 5'd0) ? 32'h0 : mregs[instr[19:15]],
                   (instr[24:20] == 5'd0) ? 32'h0 : mregs[instr[24:20]]);
    if (fl) mexp = '0;
    else if (!st) mexp = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs [8];
    exp_t        held;
    logic [31:0] r;
    logic [6:0]  opc;
    logic [6:0]  legal [9];
    logic [6:0]  bad [4];
    logic [4:0]  wrd;

    legal = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
    bad   = '{7'h7F, 7'h0F, 7'h73, 7'h0B};

    vecs[0] = '{32'h0050_0093, 32'h10, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0,
                mkexp(1'b1, 32'h10, 32'h5, 32'h0, 32'h0, 5'd1, 3'd0, A_ADD, 8'b1000_0100)};
    vecs[1] = '{32'h0021_01B3, 32'h14, 1'b1, 5'd2, 32'hDEAD_BEEF, 1'b0, 1'b0,
                mkexp(1'b1, 32'h14, 32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 5'd3, 3'd0, A_ADD, 8'b1000_0000)};
    vecs[2] = '{32'hFE00_0CE3, 32'h18, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0,
                mkexp(1'b1, 32'h18, 32'hFFFF_FFF8, 32'h0, 32'h0, 5'd25, 3'd0, A_SUB, 8'b0001_0000)};
    vecs[3] = '{32'h1234_52B7, 32'h1C, 1'b1, 5'd0, 32'h0000_FFFF, 1'b0, 1'b0,
                mkexp(1'b1, 32'h1C, 32'h1234_5000, 32'h0, 32'h0, 5'd5, 3'd5, A_PASSB, 8'b1000_0100)};
    vecs[4] = '{32'h0020_03B3, 32'h20, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0,
                mkexp(1'b1, 32'h20, 32'h0, 32'h0, 32'hDEAD_BEEF, 5'd7, 3'd0, A_ADD, 8'b1000_0000)};
    vecs[5] = '{32'h0000_007F, 32'h24, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0,
                mkexp(1'b1, 32'h24, 32'h0, 32'h0, 32'h0, 5'd0, 3'd0, A_ADD, 8'b0000_0001)};
    vecs[6] = '{32'h0000_0000, 32'h28, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, exp_t'(0)};
    vecs[7] = '{32'h0050_0093, 32'h2C, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, exp_t'(0)};

    rst = 1'b1; InstrD = 32'h0; PC_DE = 32'h0; FLUSH = 1'b0; STALL = 1'b0;
    WB_EN = 1'b0; WB_RD = 5'd0; WB_DATA = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset", dut_out(), exp_t'(0));
    rst = 1'b0;

    for (int v = 0; v < 8; v++) begin
      apply(vecs[v].instr, vecs[v].pc, vecs[v].wen, vecs[v].wrd, vecs[v].wdata,
            vecs[v].flush, vecs[v].stall);
      check($sformatf("vec%0d", v), dut_out(), vecs[v].exp);
    end

    // Stall holds the register for three cycles while fetch presents something else.
    held = mkexp(1'b1, 32'h40, 32'h5, 32'h0, 32'h0, 5'd1, 3'd0, A_ADD, 8'b1000_0100);
    apply(32'h0050_0093, 32'h40, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    check("stall_load", dut_out(), held);
    for (int s = 0; s < 3; s++) begin
      apply(32'h1234_52B7, 32'h50, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
      check($sformatf("stall_hold%0d", s), dut_out(), held);
    end

    // Write x1, read it back, then an asynchronous reset mid-cycle clears everything.
    apply(32'h0, 32'h54, 1'b1, 5'd1, 32'h0000_1234, 1'b0, 1'b0);
    apply(32'h0000_8433, 32'h58, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    check("x1_read", dut_out(),
          mkexp(1'b1, 32'h58, 32'h0, 32'h0000_1234, 32'h0, 5'd8, 3'd0, A_ADD, 8'b1000_0000));
    #3 rst = 1'b1;
    #1 check("async_rst", dut_out(), exp_t'(0));
    #1 rst = 1'b0;
    model_reset();
    apply(32'h0000_8433, 32'h60, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    check("x1_after_rst", dut_out(),
          mkexp(1'b1, 32'h60, 32'h0, 32'h0, 32'h0, 5'd8, 3'd0, A_ADD, 8'b1000_0000));

    // Randomized traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      r = $urandom();
      case ($urandom_range(0, 11))
        10:      opc = bad[$urandom_range(0, 3)];
        11:      opc = 7'h00;
        default: opc = legal[$urandom_range(0, 8)];
      endcase
      r = (opc == 7'h00 && $urandom_range(0, 1) == 0) ? 32'h0 : {r[31:7], opc};
      wrd = ($urandom_range(0, 3) == 0) ? r[19:15] : 5'($urandom_range(0, 31));
      apply(r, $urandom(), 1'($urandom_range(0, 1)), wrd, $urandom(),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 6) == 0));
      check($sformatf("rand%0d", n), dut_out(), mexp);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Second pipeline stage of the RV32I core: takes the instruction word and PC registered by the fetch stage, decodes them, reads the register file and generates the immediate. All results go into a decode/execute pipeline register that feeds the execute stage. It owns the architectural register file and its writeback port, and it inserts bubbles on redirect (flush) and holds on stall.

## Interface
Parameters:
- XLEN, 32, datapath width; only 32 supported.
- NREGS, 32, architectural register count; x0 hardwired to zero.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high; clears all state immediately.
- InstrD  in  32  instruction word from fetch; 32'h0 is a bubble.
- PC_DE  in  32  PC of InstrD.
- FLUSH  in  1  redirect from execute (same signal fetch uses as PC_R); kills the instruction being decoded.
- STALL  in  1  hazard hold; the decode/execute register keeps its contents.
- WB_EN  in  1  register write enable.
- WB_RD  in  5  write address.
- WB_DATA  in  32  write data.
- VALID_EX  out  1  the decode/execute register holds a real instruction.
- PC_EX  out  32  registered PC.
- IMM_EX  out  32  registered sign-extended immediate; doubles as PC_DISP for fetch.
- RS1_VAL_EX, RS2_VAL_EX  out  32 each  registered operand values.
- RD_EX  out  5  destination register.
- FUNCT3_EX  out  3  instr[14:12], passed through.
- ALU_OP_EX  out  4  ALU operation code (package enum).
- REG_WE_EX, MEM_RE_EX, MEM_WE_EX, BRANCH_EX, JUMP_EX, ALU_SRC_IMM_EX, ALU_SRC_PC_EX, ILLEGAL_EX  out  1 each  control bits.

## Operation
- **Opcode decode (instr[6:0]):**
  - LUI: ALU_OP=PASSB, IMM=U, REG_WE=1, SRC_IMM=1.
  - AUIPC: ADD, U, REG_WE=1, SRC_PC=1, SRC_IMM=1.
  - JAL: ADD, J, REG_WE=1, JUMP=1, SRC_PC=1, SRC_IMM=1.
  - JALR: ADD, I, REG_WE=1, JUMP=1, SRC_IMM=1.
  - BRANCH: SUB, B, BRANCH=1.
  - LOAD: ADD, I, MEM_RE=1, REG_WE=1, SRC_IMM=1.
  - STORE: ADD, S, MEM_WE=1, SRC_IMM=1.
  - OP-IMM: ALU_OP from funct3, I; SRAI when funct3=101 and instr[30]=1.
  - OP: ALU_OP from funct3 and instr[30] (SUB/SRA).
- **Illegal:** any other opcode asserts ILLEGAL=1 with every other control bit 0. ILLEGAL_EX is asserted with VALID_EX=1.
- **Immediate formats:**
  - I = sext(i[31:20])
  - S = sext({i[31:25],i[11:7]})
  - B = sext({i[31],i[7],i[30:25],i[11:8],0})
  - U = {i[31:12],12'h0}
  - J = sext({i[31],i[19:12],i[20],i[30:21],0})
  - All other opcodes: 0.
- **Register file:** 32x32, combinational read, synchronous write.
  - A write occurs on the rising edge when WB_EN=1 and WB_RD!=0.
  - A write to x0 is ignored.
  - Read bypass: when WB_EN=1 and WB_RD equals rs (rs!=0) in the same cycle, the read returns WB_DATA.
  - Reading x0 always returns 0.
- **Bubble:** InstrD==32'h0 yields VALID=0 with all control bits 0 and no ILLEGAL.
- **Register update priority per edge:** FLUSH loads a bubble (VALID=0, all control 0, data fields 0); else STALL holds; else the register loads the decode result.
  - FLUSH beats STALL.
  - The register file writes regardless of STALL and FLUSH.

## Timing
- Reset (asynchronous, immediate): all outputs 0 and every register-file entry 0. Reset asserted mid-operation discards the in-flight instruction. The first valid output comes one edge after rst deasserts and a non-zero InstrD arrives.
- Latency: 1 cycle; InstrD/PC_DE sampled at edge n appear on the *_EX outputs after edge n.
- A writeback at edge n is visible to an instruction decoded in the same cycle through the bypass, so there is no writeback-to-decode hazard.
- STALL held for k cycles keeps the outputs constant for k cycles; fetch is responsible for holding InstrD.

## Structure
- Package rv_pkg holds:
  - opcode constants;
  - the ALU_OP enum: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, PASSB=10;
  - the immediate-format enum.
- Sub-module register_file: 2 read ports, 1 write port, bypass included.
- Decode logic and the immediate generator are combinational inside decode_stage. The pipeline register is a single always block.

## Test plan
- addi x1,x0,5 (0x00500093), PC_DE=0x10 -> next cycle: VALID=1, PC_EX=0x10, IMM=5, RD=1, RS1_VAL=0, ALU_OP=ADD, REG_WE=1, SRC_IMM=1.
- WB_EN=1, WB_RD=2, WB_DATA=0xDEADBEEF in the same cycle as add x3,x2,x2 (0x002101B3) -> RS1_VAL=RS2_VAL=0xDEADBEEF, ALU_OP=ADD, SRC_IMM=0.
- beq x0,x0,-8 (0xFE000CE3) -> IMM=0xFFFFFFF8, BRANCH=1, ALU_OP=SUB, FUNCT3=0, REG_WE=0.
- lui x5,0x12345 (0x123452B7) -> IMM=0x12345000, RD=5, ALU_OP=PASSB. Write x0 with 0xFFFF, then read x0 -> 0.
- FLUSH and STALL together with a valid instruction -> VALID=0 and all control 0. STALL alone for 3 cycles -> outputs unchanged.
- Opcode 0x7F -> ILLEGAL=1, VALID=1, others 0. Asynchronous rst pulse mid-cycle -> all outputs 0 immediately, and a subsequent read of x1 returns 0.
